// File: rtl/note_pkg.sv
// ============================================================================
// Module      : note_pkg
// Description : Shared note-lane types and constants (time width, "no note"
//               encoding, time unit, feeder state enum).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package note_pkg;

  localparam int               NOTE_TIME_W  = 18;
  localparam logic [17:0]      NOTE_NONE    = 18'h3FFFF;
  // One note-time LSB is 10 ms.
  localparam int               NOTE_TICK_US = 10000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } feed_state_t;

endpackage

`default_nettype wire

// File: rtl/note_fifo.sv
// ============================================================================
// Module      : note_fifo
// Description : Synchronous first-word-fall-through FIFO with push, pop and
//               flush; DEPTH must be a power of two.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module note_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int                 c_ptr_w = $clog2(DEPTH);
  localparam logic [c_ptr_w:0]   c_full  = (c_ptr_w + 1)'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign w_do_push = push && (r_count != c_full);
  assign w_do_pop  = pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_do_push && !flush)
      r_mem[r_wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push)
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_do_pop)
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
        2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/note_feeder.sv
// ============================================================================
// Module      : note_feeder
// Description : Prefetches a lane's chart of note times from a synchronous ROM
//               into a FIFO and serves them to the matcher on note_request.
//               Optional NOTE_FEEDER_STATS_EN adds notes_served / underflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module note_feeder
  import note_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int DEPTH   = 4,
  parameter int ROM_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic                   note_request,
  output logic [NOTE_TIME_W-1:0] note_time,
  output logic [ADDR_W-1:0]      rom_addr,
  output logic                   rom_en,
  input  logic [NOTE_TIME_W-1:0] rom_data,
`ifdef NOTE_FEEDER_STATS_EN
  output logic [15:0]            notes_served,
  output logic                   underflow,
`endif
  output logic                   busy
);

  localparam int                c_cnt_w = $clog2(DEPTH) + 1;
  localparam logic [c_cnt_w:0]  c_depth = (c_cnt_w + 1)'(DEPTH);

  feed_state_t              r_state;
  feed_state_t              w_state_nxt;
  logic [ADDR_W-1:0]        r_rom_addr;
  logic                     r_addr_end;
  logic [ROM_LAT-1:0]       r_vld;
  logic [ROM_LAT-1:0]       w_vld_nxt;
  logic [c_cnt_w-1:0]       w_count;
  logic [c_cnt_w-1:0]       w_in_flight;
  logic [NOTE_TIME_W-1:0]   w_head;
  logic                     w_ret;
  logic                     w_end_ret;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_issue;

  always_comb begin
    w_in_flight = '0;
    for (int i = 0; i < ROM_LAT; i++)
      w_in_flight = w_in_flight + c_cnt_w'(r_vld[i]);
  end

  // start discards whatever returns in the same cycle.
  assign w_ret     = r_vld[ROM_LAT-1] && !start;
  assign w_end_ret = w_ret && (rom_data == NOTE_NONE);
  assign w_push    = w_ret && !w_end_ret;
  assign w_pop     = note_request && !start && (r_state != IDLE) && (w_count != '0);

  // Slots are reserved for every read still in flight, so the FIFO cannot overflow.
  assign w_issue = (r_state == FETCH) && !start && !r_addr_end && !w_end_ret &&
                   (({1'b0, w_count} + {1'b0, w_in_flight}) < c_depth);

  generate
    if (ROM_LAT == 1) begin : g_lat1
      assign w_vld_nxt = w_issue;
    end else begin : g_latn
      assign w_vld_nxt = {r_vld[ROM_LAT-2:0], w_issue};
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    if (start)
      w_state_nxt = FETCH;
    else if (r_state == FETCH) begin
      if (w_end_ret)
        w_state_nxt = DONE;
      else if (r_addr_end && (w_in_flight == '0))
        w_state_nxt = DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_addr <= '0;
      r_addr_end <= 1'b0;
      r_vld      <= '0;
    end else if (start) begin
      r_rom_addr <= base_addr;
      r_addr_end <= 1'b0;
      r_vld      <= '0;
    end else begin
      r_vld <= w_end_ret ? '0 : w_vld_nxt;
      if (w_issue) begin
        // The last address ends the chart instead of wrapping to 0.
        if (r_rom_addr == '1)
          r_addr_end <= 1'b1;
        else
          r_rom_addr <= r_rom_addr + ADDR_W'(1);
      end
    end
  end

  note_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (NOTE_TIME_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (start),
    .push  (w_push),
    .din   (rom_data),
    .pop   (w_pop),
    .head  (w_head),
    .count (w_count)
  );

`ifdef NOTE_FEEDER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      notes_served <= '0;
      underflow    <= 1'b0;
    end else if (start) begin
      notes_served <= '0;
      underflow    <= 1'b0;
    end else begin
      if (w_pop && (notes_served != 16'hFFFF))
        notes_served <= notes_served + 16'd1;
      if (note_request && (w_count == '0) && (r_state == FETCH))
        underflow <= 1'b1;
    end
  end
`endif

  assign note_time = (w_count != '0) ? w_head : NOTE_NONE;
  assign rom_addr  = r_rom_addr;
  assign rom_en    = w_issue;
  assign busy      = (r_state == FETCH);

endmodule

`default_nettype wire

// File: tb/tb_note_feeder.sv
// ============================================================================
// Module      : tb_note_feeder
// Description : Self-checking bench for note_feeder against a chart-level
//               reference queue. Also exercises NOTE_FEEDER_STATS_EN if defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_note_feeder;
  import note_pkg::*;

  localparam int AW    = 12;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          note_request = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [17:0]   note_time;
  logic [AW-1:0] rom_addr;
  logic          rom_en;
  logic [17:0]   rom_data;
  logic          busy;
`ifdef NOTE_FEEDER_STATS_EN
  logic [15:0]   notes_served;
  logic          underflow;
`endif

  int checks = 0;
  int errors = 0;

  logic [17:0] rom [0:4095];
  logic [17:0] d1, d2;
  logic [17:0] exp_q [$];

  note_feeder #(.ADDR_W(AW), .DEPTH(DEPTH), .ROM_LAT(LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_addr    (base_addr),
    .note_request (note_request),
    .note_time    (note_time),
    .rom_addr     (rom_addr),
    .rom_en       (rom_en),
    .rom_data     (rom_data),
`ifdef NOTE_FEEDER_STATS_EN
    .notes_served (notes_served),
    .underflow    (underflow),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Synchronous chart memory with LAT cycles of read latency.
  always @(posedge clk) begin
    if (rom_en) d1 <= rom[rom_addr];
    d2 <= d1;
  end
  assign rom_data = (LAT == 1) ? d1 : d2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected note sequence: chart entries from base up to the sentinel or the last address.
  task automatic build_exp(input logic [AW-1:0] b);
    int a;
    exp_q.delete();
    a = int'(b);
    while (rom[a] != NOTE_NONE) begin
      exp_q.push_back(rom[a]);
      if (a == 4095) break;
      a++;
    end
  endtask

  task automatic load_chart(input int b, input int n, input logic [17:0] first);
    logic [17:0] v;
    v = first;
    for (int i = 0; i < n; i++) begin
      rom[b + i] = v;
      v = v + 18'($urandom_range(1, 300));
    end
    if (b + n <= 4095) rom[b + n] = NOTE_NONE;
  endtask

  task automatic pulse_start(input logic [AW-1:0] b);
    base_addr = b;
    build_exp(b);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [17:0] exp_head();
    return (exp_q.size() > 0) ? exp_q[0] : NOTE_NONE;
  endfunction

  task automatic pop_once();
    note_request = 1'b1;
    tick();
    note_request = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (note_time !== NOTE_NONE) begin errors++; $display("FAIL reset_note_time: got %h expected %h", note_time, NOTE_NONE); end
    checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL reset_rom_en: got %b expected 0", rom_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (rom_addr !== '0) begin errors++; $display("FAIL reset_rom_addr: got %h expected 0", rom_addr); end
`ifdef NOTE_FEEDER_STATS_EN
    checks++; if (notes_served !== 16'd0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_stats: got %h/%b expected 0/0", notes_served, underflow); end
`endif
    rst_n = 1'b1;
    repeat (4) tick();
    checks++; if (busy !== 1'b0 || rom_en !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got busy=%b rom_en=%b expected 0/0", busy, rom_en); end
  endtask

  task automatic test_basic();
    rom[0] = 18'd100; rom[1] = 18'd250; rom[2] = 18'd400; rom[3] = NOTE_NONE;
    pulse_start(12'h000);
    repeat (LAT) tick();
    checks++; if (note_time !== NOTE_NONE) begin errors++; $display("FAIL basic_early: got %h expected %h", note_time, NOTE_NONE); end
    tick();
    checks++; if (note_time !== exp_head()) begin errors++; $display("FAIL basic_latency: got %h expected %h", note_time, exp_head()); end
    repeat (10) tick();
    checks++; if (rom_addr !== 12'd4) begin errors++; $display("FAIL basic_rom_addr: got %h expected 4", rom_addr); end
    checks++; if (busy !== 1'b0 || rom_en !== 1'b0) begin errors++; $display("FAIL basic_done: got busy=%b rom_en=%b expected 0/0", busy, rom_en); end
    for (int k = 0; k < 3; k++) begin
      pop_once();
      tick();
      checks++; if (note_time !== exp_head()) begin errors++; $display("FAIL basic_pop%0d: got %h expected %h", k, note_time, exp_head()); end
    end
  endtask

  task automatic test_empty_pop();
    load_chart(12'h100, 5, 18'd1000);
    pulse_start(12'h100);
    note_request = 1'b1;
    tick();
    note_request = 1'b0;
    checks++; if (note_time !== NOTE_NONE || busy !== 1'b1) begin errors++; $display("FAIL empty_pop: got %h busy=%b expected %h busy=1", note_time, busy, NOTE_NONE); end
`ifdef NOTE_FEEDER_STATS_EN
    checks++; if (underflow !== 1'b1 || notes_served !== 16'd0) begin errors++; $display("FAIL empty_pop_stats: got %b/%h expected 1/0", underflow, notes_served); end
`endif
    repeat (LAT) tick();
    checks++; if (note_time !== exp_head()) begin errors++; $display("FAIL empty_pop_first: got %h expected %h", note_time, exp_head()); end
  endtask

  task automatic test_prefetch();
    load_chart(12'h200, 10, 18'd2000);
    pulse_start(12'h200);
    repeat (12) tick();
    checks++; if (rom_addr !== 12'h204 || rom_en !== 1'b0) begin errors++; $display("FAIL prefetch_fill: got addr=%h en=%b expected 204/0", rom_addr, rom_en); end
    checks++; if (note_time !== exp_head()) begin errors++; $display("FAIL prefetch_head: got %h expected %h", note_time, exp_head()); end
    pop_once();
    repeat (8) tick();
    checks++; if (rom_addr !== 12'h205 || rom_en !== 1'b0) begin errors++; $display("FAIL prefetch_refill: got addr=%h en=%b expected 205/0", rom_addr, rom_en); end
    checks++; if (note_time !== exp_head()) begin errors++; $display("FAIL prefetch_next: got %h expected %h", note_time, exp_head()); end
`ifdef NOTE_FEEDER_STATS_EN
    checks++; if (notes_served !== 16'd1 || underflow !== 1'b0) begin errors++; $display("FAIL prefetch_stats: got %h/%b expected 1/0", notes_served, underflow); end
`endif
  endtask

  task automatic test_restart();
    load_chart(12'h300, 10, 18'd3000);
    load_chart(12'h020, 6, 18'd50000);
    pulse_start(12'h300);
    repeat (LAT) tick();
    pulse_start(12'h020);
    checks++; if (note_time !== NOTE_NONE) begin errors++; $display("FAIL restart_flush: got %h expected %h", note_time, NOTE_NONE); end
    repeat (LAT) tick();
    checks++; if (note_time !== NOTE_NONE) begin errors++; $display("FAIL restart_stale: got %h expected %h", note_time, NOTE_NONE); end
    tick();
    checks++; if (note_time !== rom[12'h020]) begin errors++; $display("FAIL restart_first: got %h expected %h", note_time, rom[12'h020]); end
  endtask

  task automatic test_back_to_back();
    logic [17:0] nt;
    load_chart(12'h400, 12, 18'd7000);
    pulse_start(12'h400);
    for (int c = 0; c < 60; c++) begin
      nt = note_time;
      note_request = 1'b1;
      if (nt !== NOTE_NONE) begin
        checks++; if (nt !== exp_head()) begin errors++; $display("FAIL b2b_cycle%0d: got %h expected %h", c, nt, exp_head()); end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      tick();
    end
    note_request = 1'b0;
    tick();
    checks++; if (exp_q.size() != 0 || note_time !== NOTE_NONE || busy !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %h left=%0d busy=%b expected %h left=0 busy=0", note_time, exp_q.size(), busy, NOTE_NONE); end
  endtask

  task automatic test_random();
    logic [17:0] nt;
    logic        req;
    int          b, n;
    for (int it = 0; it < 8; it++) begin
      b = int'($urandom_range(16'h600, 16'hE00));
      n = int'($urandom_range(0, 12));
      load_chart(b, n, 18'($urandom_range(0, 100000)));
      pulse_start(AW'(b));
      for (int c = 0; c < 80; c++) begin
        nt = note_time;
        req = ($urandom_range(0, 2) == 0);
        note_request = req;
        if (nt !== NOTE_NONE) begin
          checks++; if (nt !== exp_head()) begin errors++; $display("FAIL rand%0d_cycle%0d: got %h expected %h", it, c, nt, exp_head()); end
          if (req && exp_q.size() > 0) void'(exp_q.pop_front());
        end
        tick();
      end
      note_request = 1'b0;
      repeat (8) tick();
      checks++; if (note_time !== exp_head()) begin errors++; $display("FAIL rand%0d_settled: got %h expected %h", it, note_time, exp_head()); end
    end
  endtask

  task automatic test_wrap();
    rom[4094] = 18'd60000;
    rom[4095] = 18'd60100;
    pulse_start(12'hFFE);
    repeat (12) tick();
    checks++; if (busy !== 1'b0 || rom_en !== 1'b0) begin errors++; $display("FAIL wrap_done: got busy=%b en=%b expected 0/0", busy, rom_en); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (note_time !== exp_head()) begin errors++; $display("FAIL wrap_note%0d: got %h expected %h", k, note_time, exp_head()); end
      pop_once();
      tick();
    end
  endtask

  task automatic test_async_reset();
    load_chart(12'h500, 10, 18'd9000);
    pulse_start(12'h500);
    repeat (LAT + 2) tick();
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (note_time !== NOTE_NONE || rom_en !== 1'b0 || busy !== 1'b0 || rom_addr !== '0) begin errors++; $display("FAIL async_reset: got nt=%h en=%b busy=%b addr=%h expected %h/0/0/0", note_time, rom_en, busy, rom_addr, NOTE_NONE); end
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    checks++; if (note_time !== NOTE_NONE || rom_en !== 1'b0 || busy !== 1'b0 || rom_addr !== '0) begin errors++; $display("FAIL post_reset_idle: got nt=%h en=%b busy=%b addr=%h expected %h/0/0/0", note_time, rom_en, busy, rom_addr, NOTE_NONE); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 18'($urandom_range(0, 18'h3FFFE));
    test_reset();
    test_basic();
    test_empty_pop();
    test_prefetch();
    test_restart();
    test_back_to_back();
    test_random();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/note_feeder.md
Name: note_feeder

Overview:
Supplies note times to one note-matching lane, answering its note_request pulses with the next chart entry. Reads a per-lane chart of 18-bit note times (10 ms units) from a synchronous ROM/BRAM and prefetches entries into a small FIFO so note_time is always valid one cycle after a pop. Drives all-ones on note_time when no note is available, which is the "no note" encoding the matcher expects. One instance per lane, between the chart memory and the lane's note matcher.

Parameters:
ADDR_W, 12, chart ROM address width
DEPTH, 4, prefetch FIFO depth (power of 2, >=2)
ROM_LAT, 1, ROM read latency in cycles (1 or 2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse: flush and begin feeding from base_addr
base_addr  in  ADDR_W  first chart address for this lane, sampled on start
note_request  in  1  pop pulse from matcher
note_time  out  18  head note time, 18'h3FFFF when none
rom_addr  out  ADDR_W  chart read address
rom_en  out  1  chart read strobe
rom_data  in  18  chart word, valid ROM_LAT cycles after rom_en
busy  out  1  high while in FETCH

Behaviour:
- Reset (async, rst_n low): state IDLE, FIFO count 0, in-flight count 0, rom_addr 0, rom_en 0, busy 0. note_time reads 18'h3FFFF.
- note_time is combinational from the FIFO head: head entry when count>0, else 18'h3FFFF.
- FSM IDLE: ignore note_request. On start, load rom_addr<=base_addr, flush FIFO, go to FETCH.
- FSM FETCH: assert rom_en when count+in_flight<DEPTH. rom_addr increments on each issued read.
- Each returned word is a push into the FIFO.
- A returned word of 18'h3FFFF is the end-of-chart sentinel. It is not pushed; drop any later in-flight returns and go to DONE.
- If rom_addr would wrap past 2^ADDR_W-1, treat it as end-of-chart: issue no more reads, go to DONE once in_flight reaches 0.
- FSM DONE: no reads; FIFO drains via pops. start goes back to FETCH.
- busy=1 only in FETCH.
- In-flight tracking: a shift register of depth ROM_LAT marks valid returns. in_flight is its popcount.
- Pop: note_request high at a clk edge with count>0 removes the head. The new head appears on note_time the next cycle.
- Pop when count==0 is ignored and nothing changes.
- Push and pop in the same cycle: both take effect and count is unchanged. A push into an empty FIFO is visible on note_time the next cycle.
- FIFO never overflows, because the issue rule reserves slots for in-flight reads.
- start mid-operation (any state) has priority over note_request:
  - clear FIFO and invalidate all in-flight returns (clear the valid shift register);
  - restart from the new base_addr;
  - note_time is 18'h3FFFF the following cycle.
- Pointer arithmetic is modulo DEPTH; count is log2(DEPTH)+1 bits wide.
- Latency from start to first valid note_time: ROM_LAT+2 cycles.

Optional Feature:
NOTE_FEEDER_STATS_EN
- When defined, adds outputs notes_served (16-bit, counts successful pops, saturating at 16'hFFFF) and underflow (sticky; set when note_request arrives with count==0 while in FETCH).
- Both clear on reset and on start.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package (note_pkg): NOTE_TIME_W=18, NOTE_NONE=18'h3FFFF, the 10 ms time unit constant, and the state enum {IDLE, FETCH, DONE}. The matcher shares the same package.
- One sub-module, note_fifo: synchronous FIFO, DEPTH parameter, push/pop/flush, count, first-word-fall-through head output.

Test Plan:
- Reset then start with base_addr=0 and ROM [100,250,400,FFFF] (ROM_LAT=1) → note_time=100 by cycle 3; three pops spaced 2 cycles yield 250, 400, then 3FFFF; state DONE; rom_addr stops at 4.
- Pop with empty FIFO (immediately after start) → note_time stays 3FFFF, no state change; with STATS_EN, underflow=1 and notes_served=0.
- ROM of 10 ascending notes, DEPTH=4, no pops → exactly 4 words buffered, rom_en deasserted; one pop → exactly one new read issued, count returns to 4.
- start pulsed mid-FETCH with base_addr=0x20 while one read is in flight (ROM_LAT=2) → stale return discarded; next note_time equals ROM[0x20].
- Simultaneous push and pop at count=2 → count stays 2; head advances to the next entry in order.
- rst_n asserted asynchronously mid-fetch (not on a clk edge) → all outputs reach reset values immediately; after release, nothing happens until start.
